spi_arbiter: RTL
================

# spi_arbiter

Round-robin scheduler that shares one `spi_master` between `NREQ` requesters. It latches the winning requester's word, fires a one-cycle start strobe into the master, and waits for the master's completion strobe. It then acknowledges the requester and re-arbitrates. It sits between the board-level command sources (UART bridge, LED/display drivers, sensor pollers) and the single SPI master instance.

## Interface
Parameters:
- `WIDTH`, 13: SPI word width; must match the attached `spi_master`.
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in clk cycles. Used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: per-requester request level.
- `req_data`  in  NREQ*WIDTH: per-requester word. Requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `gnt`  out  NREQ: one-hot grant, held for the whole transfer.
- `ack`  out  NREQ: one-cycle completion pulse to the granted requester.
- `timeout`  out  1: one-cycle pulse when a transfer is aborted by the watchdog.
- `spi_st`  out  1: start strobe to `spi_master.st`.
- `spi_din`  out  WIDTH: registered word to `spi_master.din`.
- `spi_done`  in  1: one-cycle completion strobe from `spi_master`.

## Operation
- FSM states: IDLE, START, WAIT_DONE, ACK.
- **IDLE**
  - Sample `req`. If no bit is set, stay in IDLE.
  - Otherwise pick the winner by round-robin: search upward from pointer `ptr`, wrapping modulo NREQ.
  - Register `sel` = winner, `spi_din` = the winner's slice, and `gnt[sel]` = 1. Go to START.
- **START**
  - `spi_st` = 1 for exactly this cycle. Go to WAIT_DONE.
  - `spi_done` is ignored in this state.
- **WAIT_DONE**
  - Hold `gnt` and `spi_din`.
  - When `spi_done` = 1, go to ACK.
- **ACK**
  - `ack[sel]` = 1 for this cycle; `gnt` stays asserted this cycle.
  - Update `ptr` = (sel+1) mod NREQ. Go to IDLE.
- Request sampling:
  - Only `req` sampled in IDLE counts.
  - A requester may drop `req` after seeing `gnt`. Its data is already latched.
  - A requester that keeps `req` high after `ack` is treated as a new request.
- Round-robin fairness: the same requester cannot win twice in a row while another requester is pending.
- Simultaneous events:
  - Several requests in IDLE: the one nearest `ptr` (upward) wins.
  - `spi_done` seen in IDLE or START: ignored, no state change.
- Reset:
  - Every output goes to 0 (`gnt`, `ack`, `timeout`, `spi_st`, `spi_din`).
  - `ptr` = 0, `sel` = 0, state = IDLE.
  - Reset asserted mid-transfer aborts the transfer with no `ack`. The attached `spi_master` shares `rst_n`.

## Timing
- `req` high in IDLE at cycle N:
  - `gnt` and `spi_din` valid at N+1.
  - `spi_st` high only at N+1.
- `spi_done` at cycle M: `ack` at M+1 and `gnt` still high at M+1; `gnt` low at M+2.
- Back-to-back turnaround: a pending request gets `spi_st` at M+3, which gives 2 idle cycles between transfers.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT_DONE and increments each cycle spent there.
  - If it reaches `TIMEOUT_CYCLES-1` without `spi_done`, go to ACK.
  - `ack[sel]` and `timeout` pulse in that same cycle.
  - The counter is `$clog2(TIMEOUT_CYCLES)` bits wide.
- **Undefined:** no counter is built, `timeout` is tied to 0, and WAIT_DONE waits indefinitely.

## Structure
- Shared package `spi_pkg` holds:
  - the `spi_arb_state_t` enum (IDLE, START, WAIT_DONE, ACK);
  - the default `WIDTH` localparam shared with `spi_master`.
- Sub-module `spi_rr_pick`: purely combinational round-robin priority encoder.
  - Inputs: `req` and `ptr`.
  - Outputs: `valid` and winner index.
- The FSM and registers live in `spi_arbiter`.

## Test plan
Common setup: WIDTH=13, NREQ=4. The `spi_master` stub asserts `spi_done` 8 cycles after `spi_st`.

1. Reset, then `req`=0001 with `req_data[0]`=13'h1249 → `spi_st` pulses once, `spi_din`=13'h1249, `gnt`=0001, `ack`=0001 one cycle after `spi_done`.
2. `req`=1111 held high for 4 transfers → grants in order 0001, 0010, 0100, 1000, then 0001 again, with 2 idle cycles between transfers.
3. `req`=0101 with `ptr`=1 → requester 2 wins first, then requester 0. Requester 2 is not re-granted while requester 0 is pending.
4. `spi_done` pulsed in IDLE and in START → no state change, no `ack`.
5. `rst_n` low during WAIT_DONE → all outputs 0 immediately and no `ack`. After release, `req`=0010 is granted with `ptr` reset to 0.
6. With `SPI_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, the stub never asserts done → `timeout` and `ack[sel]` pulse 16 cycles after entering WAIT_DONE, then the FSM returns to IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI arbiter and the SPI master.
//   SPI_WIDTH       - default SPI word width (must match spi_master)
//   spi_arb_state_t - arbiter FSM states (IDLE, START, WAIT_DONE, ACK)
package spi_pkg;

  localparam int SPI_WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } spi_arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: purely combinational round-robin priority encoder.
// Searches upward from ptr_i (wrapping modulo NREQ) for the first set request.
// Ports:
//   req_i   in  NREQ : request vector
//   ptr_i   in  PW   : index with highest priority
//   valid_o out 1    : at least one request is set
//   idx_o   out PW   : winning requester index (0 when valid_o is low)
module spi_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [PW-1:0]   idx_o
);

  logic [PW-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest set request
  // (starting at ptr_i) is the last assignment and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_i) + k) % NREQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin scheduler sharing one spi_master among NREQ
// requesters. Latches the winner's word, pulses spi_st for one cycle, waits
// for spi_done, then pulses ack to the winner and re-arbitrates.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES cycles in WAIT_DONE (ack and timeout pulse together).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          in  NREQ       : request levels (sampled only in IDLE)
//   req_data     in  NREQ*WIDTH : words, requester i at [i*WIDTH +: WIDTH]
//   gnt          out NREQ       : one-hot grant, held through ACK
//   ack          out NREQ       : one-cycle completion pulse
//   timeout      out 1          : one-cycle watchdog abort pulse
//   spi_st       out 1          : start strobe to spi_master
//   spi_din      out WIDTH      : latched word to spi_master
//   spi_done     in  1          : completion strobe from spi_master
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int WIDTH          = SPI_WIDTH,
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  timeout,
  output logic                  spi_st,
  output logic [WIDTH-1:0]      spi_din,
  input  logic                  spi_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("spi_arbiter: NREQ must be within 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  spi_arb_state_t  state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   sel_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            spi_st_q;
  logic            timeout_q;
  logic [WIDTH-1:0] spi_din_q;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [WIDTH-1:0] data_arr [NREQ];
  logic             wd_expired;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  spi_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wd_cnt_q;

  // Held at zero outside WAIT_DONE, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q != WAIT_DONE) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + CW'(1);
    end
  end

  assign wd_expired = (state_q == WAIT_DONE) && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      spi_st_q  <= 1'b0;
      timeout_q <= 1'b0;
      spi_din_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            sel_q     <= pick_idx;
            spi_din_q <= data_arr[pick_idx];
            gnt_q     <= NREQ'(1) << pick_idx;
            spi_st_q  <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          // spi_done is deliberately ignored here.
          spi_st_q <= 1'b0;
          state_q  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (spi_done || wd_expired) begin
            ack_q     <= gnt_q;
            // A real completion in the same cycle as expiry is not a timeout.
            timeout_q <= ~spi_done;
            state_q   <= ACK;
          end
        end
        ACK: begin
          ack_q     <= '0;
          timeout_q <= 1'b0;
          gnt_q     <= '0;
          ptr_q     <= (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign timeout = timeout_q;
  assign spi_st  = spi_st_q;
  assign spi_din = spi_din_q;

endmodule
